dvi_clk_rst_seq: RTL and testbench

- Parametrised MMCM/PLL reset and lock supervisor for DVI/HDMI TX clocking; successor to the single-FSM MMCM-reset/BUFR-reset logic.
- Adds programmable reset pulse width, lock debounce, lock timeout with bounded retries, and staggered per-domain reset release.
- Adds sticky fail reporting and lock-loss statistics.
- Runs on the reference clock, drives the MMCM RST pin, the BUFR reset and N downstream domain resets.

---
 rtl/dvi_clk_rst_seq.sv | 198 +++++++++++++++++++
 tb/tb_dvi_clk_rst_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_clk_rst_seq.sv
// MMCM/PLL reset and lock supervisor for DVI/HDMI TX clocking: pulses the MMCM reset,
// debounces LOCKED with timeout/retry, then pulses BUFR reset and releases domains in order.
module dvi_clk_rst_seq #(
    parameter int unsigned RST_PULSE_CYCLES = 4,
    parameter int unsigned LOCK_FILTER      = 16,
    parameter int unsigned LOCK_TIMEOUT     = 65536,
    parameter int unsigned MAX_RETRIES      = 7,
    parameter int unsigned N_DOMAINS        = 3,
    parameter int unsigned STAGGER_CYCLES   = 8
) (
    input  logic                               i_clk,
    input  logic                               i_srst_n,
    input  logic                               i_locked,
    input  logic                               i_force_reset,
    output logic                               o_pll_rst,
    output logic                               o_bufr_rst,
    output logic [N_DOMAINS-1:0]               o_domain_rst,
    output logic                               o_locked_stable,
    output logic                               o_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
    output logic [7:0]                         o_lock_loss_cnt
);

    localparam int unsigned PulseW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned FltW   = $clog2(LOCK_FILTER + 1);
    localparam int unsigned StgMax = STAGGER_CYCLES * N_DOMAINS;
    localparam int unsigned StgW   = $clog2(StgMax + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [PulseW-1:0] PulseLast = PulseW'(RST_PULSE_CYCLES - 1);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(LOCK_TIMEOUT - 1);
    localparam logic [FltW-1:0]   FltLast   = FltW'(LOCK_FILTER - 1);
    localparam logic [StgW-1:0]   StgLast   = StgW'(StgMax);
    localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPulse = 3'd0,
        StWaitLock   = 3'd1,
        StFilter     = 3'd2,
        StBufrRst    = 3'd3,
        StRelease    = 3'd4,
        StRun        = 3'd5,
        StFail       = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                lock_s;
    logic [PulseW-1:0]   pulse_q, pulse_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [FltW-1:0]     flt_q, flt_d;
    logic [StgW-1:0]     stg_q, stg_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [7:0]          loss_q, loss_d;
    logic                pll_rst_d, bufr_rst_d, stable_d, fail_d;
    logic [N_DOMAINS-1:0] dom_rst_d;
    logic                timeout;

    assign lock_s  = sync_q[1];
    assign timeout = (tmo_q == TmoLast);

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        tmo_d   = tmo_q;
        flt_d   = flt_q;
        stg_d   = stg_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (i_force_reset) begin
            state_d = StResetPulse;
            pulse_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                StResetPulse: begin
                    if (pulse_q == PulseLast) begin
                        state_d = StWaitLock;
                        tmo_d   = '0;
                        flt_d   = '0;
                    end else begin
                        pulse_d = pulse_q + PulseW'(1);
                    end
                end
                StWaitLock, StFilter: begin
                    if (state_q == StFilter && lock_s && flt_q == FltLast) begin
                        state_d = StBufrRst;
                    end else if (timeout) begin
                        pulse_d = '0;
                        if (retry_q < RetryMax) begin
                            retry_d = retry_q + RetryW'(1);
                            state_d = StResetPulse;
                        end else begin
                            state_d = StFail;
                        end
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                        if (!lock_s) begin
                            state_d = StWaitLock;
                            flt_d   = '0;
                        end else if (state_q == StWaitLock) begin
                            state_d = StFilter;
                            flt_d   = '0;
                        end else begin
                            flt_d = flt_q + FltW'(1);
                        end
                    end
                end
                StBufrRst: begin
                    if (!lock_s) begin
                        state_d = StResetPulse;
                        pulse_d = '0;
                    end else begin
                        state_d = StRelease;
                        stg_d   = '0;
                    end
                end
                StRelease: begin
                    if (!lock_s) begin
                        state_d = StResetPulse;
                        pulse_d = '0;
                    end else if (stg_q == StgLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end else begin
                        stg_d = stg_q + StgW'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_d = StResetPulse;
                        pulse_d = '0;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                StFail: ;
                default: begin
                    state_d = StResetPulse;
                    pulse_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        pll_rst_d  = (state_d == StResetPulse) || (state_d == StFail);
        bufr_rst_d = (state_d == StBufrRst);
        stable_d   = (state_d == StRun);
        fail_d     = (state_d == StFail);
        dom_rst_d  = '1;
        if (state_d == StRun) begin
            dom_rst_d = '0;
        end else if (state_d == StRelease) begin
            for (int k = 0; k < N_DOMAINS; k++) begin
                dom_rst_d[k] = (stg_d < StgW'(STAGGER_CYCLES * (k + 1)));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state_q         <= StResetPulse;
            sync_q          <= '0;
            pulse_q         <= '0;
            tmo_q           <= '0;
            flt_q           <= '0;
            stg_q           <= '0;
            retry_q         <= '0;
            loss_q          <= '0;
            o_pll_rst       <= 1'b1;
            o_bufr_rst      <= 1'b0;
            o_domain_rst    <= '1;
            o_locked_stable <= 1'b0;
            o_fail          <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= {sync_q[0], i_locked};
            pulse_q         <= pulse_d;
            tmo_q           <= tmo_d;
            flt_q           <= flt_d;
            stg_q           <= stg_d;
            retry_q         <= retry_d;
            loss_q          <= loss_d;
            o_pll_rst       <= pll_rst_d;
            o_bufr_rst      <= bufr_rst_d;
            o_domain_rst    <= dom_rst_d;
            o_locked_stable <= stable_d;
            o_fail          <= fail_d;
        end
    end

    assign o_retry_cnt     = retry_q;
    assign o_lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_dvi_clk_rst_seq.sv
// Directed bench for dvi_clk_rst_seq: nominal bring-up, glitchy lock, lock loss, saturation,
// force/reset, and timeout/retry/fail on a second instance with a short timeout.
module tb_dvi_clk_rst_seq;

    logic       clk = 1'b0;
    logic       srst_n, locked, force_rst;
    logic       pll_rst, bufr_rst, stable, fail;
    logic [2:0] dom_rst, retry;
    logic [7:0] loss;

    logic       t_srst_n, t_force;
    logic       t_locked = 1'b0;
    logic       t_pll, t_bufr, t_stable, t_fail;
    logic [2:0] t_dom;
    logic [1:0] t_retry;
    logic [7:0] t_loss;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dvi_clk_rst_seq dut (
        .i_clk           (clk),
        .i_srst_n        (srst_n),
        .i_locked        (locked),
        .i_force_reset   (force_rst),
        .o_pll_rst       (pll_rst),
        .o_bufr_rst      (bufr_rst),
        .o_domain_rst    (dom_rst),
        .o_locked_stable (stable),
        .o_fail          (fail),
        .o_retry_cnt     (retry),
        .o_lock_loss_cnt (loss)
    );

    dvi_clk_rst_seq #(
        .LOCK_TIMEOUT (64),
        .MAX_RETRIES  (2)
    ) dut_t (
        .i_clk           (clk),
        .i_srst_n        (t_srst_n),
        .i_locked        (t_locked),
        .i_force_reset   (t_force),
        .o_pll_rst       (t_pll),
        .o_bufr_rst      (t_bufr),
        .o_domain_rst    (t_dom),
        .o_locked_stable (t_stable),
        .o_fail          (t_fail),
        .o_retry_cnt     (t_retry),
        .o_lock_loss_cnt (t_loss)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_stable(input string tag);
        int i;
        i = 0;
        while (!stable && i < 300) begin
            tick;
            i++;
        end
        chk(tag, {31'd0, stable}, 32'd1);
    endtask

    task automatic relock_cycle;
        locked = 1'b0;
        repeat (3) tick;
        locked = 1'b1;
        wait_stable("relock_stable");
    endtask

    initial begin
        int hi, n, seen, cnt, pulses, len, in_pulse, fail_t;
        logic [2:0] exp_dom;

        srst_n = 1'b0; locked = 1'b0; force_rst = 1'b0;
        t_srst_n = 1'b0; t_force = 1'b0;
        tick;
        chk("rst_pll", {31'd0, pll_rst}, 32'd1);
        chk("rst_dom", {29'd0, dom_rst}, 32'd7);
        chk("rst_bufr", {31'd0, bufr_rst}, 32'd0);
        chk("rst_stable", {31'd0, stable}, 32'd0);
        chk("rst_fail", {31'd0, fail}, 32'd0);
        chk("rst_retry", {29'd0, retry}, 32'd0);
        chk("rst_loss", {24'd0, loss}, 32'd0);
        srst_n = 1'b1;

        // Nominal bring-up
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (pll_rst) hi++;
            else break;
        end
        chk("pll_pulse_len", hi, 32'd4);
        repeat (95) tick;
        locked = 1'b1;
        n = 0; seen = 0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            tick;
            if (bufr_rst) begin
                seen = 1;
                n = i;
            end
        end
        chk("bufr_latency", n, 32'd19);
        for (int t = 1; t <= 26; t++) begin
            tick;
            for (int k = 0; k < 3; k++) exp_dom[k] = (t < 9 + 8 * k);
            chk("release_dom", {29'd0, dom_rst}, {29'd0, exp_dom});
            chk("release_stable", {31'd0, stable}, (t >= 26) ? 32'd1 : 32'd0);
            if (t == 1) chk("bufr_single", {31'd0, bufr_rst}, 32'd0);
        end
        chk("run_retry", {29'd0, retry}, 32'd0);

        // Lock loss in RUN
        locked = 1'b0;
        tick; tick;
        chk("loss_t2_stable", {31'd0, stable}, 32'd1);
        tick;
        chk("loss_dom", {29'd0, dom_rst}, 32'd7);
        chk("loss_stable", {31'd0, stable}, 32'd0);
        chk("loss_pll", {31'd0, pll_rst}, 32'd1);
        chk("loss_cnt1", {24'd0, loss}, 32'd1);
        locked = 1'b1;
        wait_stable("reacq_stable");
        chk("reacq_retry", {29'd0, retry}, 32'd0);

        // Loss mid-RELEASE (a RUN loss first, bringing the count to 2)
        locked = 1'b0;
        repeat (3) tick;
        locked = 1'b1;
        n = 0;
        while (dom_rst !== 3'b110 && n < 300) begin
            tick;
            n++;
        end
        chk("midrel_reach", {29'd0, dom_rst}, 32'd6);
        locked = 1'b0;
        repeat (3) tick;
        chk("midrel_dom", {29'd0, dom_rst}, 32'd7);
        chk("midrel_pll", {31'd0, pll_rst}, 32'd1);
        chk("midrel_loss", {24'd0, loss}, 32'd2);
        locked = 1'b1;
        wait_stable("midrel_stable");

        // Saturation: 300 losses from RUN in total
        for (int i = 0; i < 252; i++) relock_cycle();
        chk("loss_254", {24'd0, loss}, 32'd254);
        for (int i = 0; i < 48; i++) relock_cycle();
        chk("loss_sat", {24'd0, loss}, 32'd255);

        // Force reset in RUN, held for several cycles
        force_rst = 1'b1;
        tick;
        chk("force_pll", {31'd0, pll_rst}, 32'd1);
        chk("force_dom", {29'd0, dom_rst}, 32'd7);
        chk("force_stable", {31'd0, stable}, 32'd0);
        chk("force_loss", {24'd0, loss}, 32'd255);
        repeat (5) tick;
        chk("force_held_pll", {31'd0, pll_rst}, 32'd1);
        force_rst = 1'b0;
        wait_stable("force_reacq");
        chk("force_reacq_loss", {24'd0, loss}, 32'd255);

        // Synchronous reset mid-operation
        srst_n = 1'b0;
        tick;
        srst_n = 1'b1;
        chk("srst_loss", {24'd0, loss}, 32'd0);
        chk("srst_pll", {31'd0, pll_rst}, 32'd1);
        chk("srst_dom", {29'd0, dom_rst}, 32'd7);
        chk("srst_stable", {31'd0, stable}, 32'd0);

        // Glitchy lock: high 10, low 1, high again
        locked = 1'b0;
        repeat (20) tick;
        cnt = 0;
        locked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bufr_rst) cnt++;
        end
        locked = 1'b0;
        tick;
        if (bufr_rst) cnt++;
        locked = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (bufr_rst) begin
                cnt++;
                if (n == 0) n = i;
            end
        end
        chk("glitch_bufr_latency", n, 32'd19);
        chk("glitch_bufr_count", cnt, 32'd1);
        wait_stable("glitch_stable");

        // Timeout / retry / fail on the short-timeout instance
        t_srst_n = 1'b1;
        pulses = 1; len = 1; in_pulse = 1; fail_t = 0;
        chk("t_retry0", {30'd0, t_retry}, 32'd0);
        for (int i = 1; i <= 300; i++) begin
            tick;
            if (t_fail) begin
                fail_t = i;
                break;
            end
            if (t_pll && in_pulse == 0) begin
                in_pulse = 1;
                len = 1;
                chk("t_retry_step", {30'd0, t_retry}, pulses);
                pulses++;
            end else if (t_pll) begin
                len++;
            end else if (in_pulse != 0) begin
                in_pulse = 0;
                chk("t_pulse_len", len, 32'd4);
            end
        end
        chk("t_pulse_count", pulses, 32'd3);
        chk("t_fail_time", fail_t, 32'd204);
        chk("t_fail_pll", {31'd0, t_pll}, 32'd1);
        chk("t_fail_dom", {29'd0, t_dom}, 32'd7);
        chk("t_fail_retry", {30'd0, t_retry}, 32'd2);
        repeat (10) tick;
        chk("t_fail_held", {31'd0, t_fail}, 32'd1);
        chk("t_fail_pll_held", {31'd0, t_pll}, 32'd1);
        t_force = 1'b1;
        tick;
        t_force = 1'b0;
        chk("t_force_fail", {31'd0, t_fail}, 32'd0);
        chk("t_force_retry", {30'd0, t_retry}, 32'd0);
        chk("t_force_pll", {31'd0, t_pll}, 32'd1);
        repeat (3) tick;
        chk("t_new_pulse_hi", {31'd0, t_pll}, 32'd1);
        tick;
        chk("t_new_pulse_lo", {31'd0, t_pll}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
